// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the decoder: opcode values and FSM encoding.
package instr_fetch_unit_pkg;

  localparam int unsigned OPCODE_W = 4;

  // Halt opcode; fetching stops once an instruction carrying it has been accepted.
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // True when the opcode ends the fetch stream.
  function automatic logic is_halt(input logic [OPCODE_W-1:0] op);
    return op == OP_HLT;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO holding {instr, pc} entries between memory and decode.
module instr_fetch_unit_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointers, occupancy and storage; flush empties the queue outright.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / PC sequencer feeding the decoder.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     INSTR_W   = 16,
  parameter int unsigned     BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [3:0]         id_opcode,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus1,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  , output logic [31:0]      perf_fetched
  , output logic [31:0]      perf_stall
`endif
);

  localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned ENTRY_W = INSTR_W + PC_W;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic             im_req_q, im_req_d;
  logic [PC_W-1:0]  im_addr_q, im_addr_d;
  logic             drop_q, drop_d;
  logic             halted_q, halted_d;

  logic             ack_acc;
  logic             fifo_push;
  logic             fifo_pop;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] cnt_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic [3:0]       ack_op;

  // An ack only counts against a request we actually raised.
  assign ack_acc   = im_ack & im_req_q;
  assign fifo_push = ack_acc & ~drop_q & ~redirect & ~fifo_full;
  assign fifo_pop  = ~fifo_empty & id_ready;
  assign ack_op    = im_rdata[INSTR_W-1 -: 4];

  instr_fetch_unit_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata ({im_rdata, fetch_pc_q}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign id_valid    = ~fifo_empty;
  assign id_instr    = fifo_rdata[ENTRY_W-1 -: INSTR_W];
  assign id_pc       = fifo_rdata[PC_W-1:0];
  assign id_opcode   = id_instr[INSTR_W-1 -: 4];
  assign id_pc_plus1 = id_pc + PC_W'(1);
  assign im_req      = im_req_q;
  assign im_addr     = im_addr_q;
  assign halted      = halted_q;

  // Next-state: FSM, fetch PC, drop flag and request issue based on next-cycle occupancy.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    im_req_d   = im_req_q;
    im_addr_d  = im_addr_q;
    cnt_next   = redirect ? '0 : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (fifo_push && is_halt(ack_op)) state_d = ST_HALT;
      ST_HALT:  if (redirect) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (fifo_push) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
    end

    if (ack_acc) begin
      drop_d = 1'b0;
    end else if (redirect && im_req_q) begin
      drop_d = 1'b1;
    end

    // A raised request holds address and strobe until its ack, even across a redirect.
    if (!(im_req_q && !im_ack)) begin
      im_req_d  = (state_d == ST_FETCH) && (cnt_next < CNT_W'(BUF_DEPTH));
      im_addr_d = fetch_pc_d;
    end

    halted_d = (state_d == ST_HALT) && (cnt_next == '0);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      im_req_q   <= 1'b0;
      im_addr_q  <= RESET_PC;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      im_req_q   <= im_req_d;
      im_addr_q  <= im_addr_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;

  // Saturating counts of accepted fetches and decode back-pressure cycles.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (fifo_push && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (id_valid && !id_ready && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule
